// File: rtl/regress_lane_fifo.sv
// regress_lane_fifo: lane-assembling FWFT FIFO; define REGRESS_LANE_REVERSE_EN to present the head with its lane order reversed
module regress_lane_fifo #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANE_W*LANES-1:0]        in_data,
    input  logic [LANES-1:0]               in_mask,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANE_W*LANES-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int WIDTH = LANE_W * LANES;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    bit   [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] staging;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] shown;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             commit;
    logic             pop;

    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign commit    = push && in_last;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];

`ifdef REGRESS_LANE_REVERSE_EN
    assign shown = {<<LANE_W{head}};
`else
    assign shown = head;
`endif

    assign out_data = out_valid ? shown : '0;

    // overlay this beat's enabled lanes on the staging word
    always_comb begin
        merged = staging;
        for (int l = 0; l < LANES; l++)
            if (in_mask[l]) merged[l*LANE_W +: LANE_W] = in_data[l*LANE_W +: LANE_W];
    end

    // pointers, occupancy and staging; pointers wrap at DEPTH-1 rather than a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            staging <= '0;
        end else begin
            if (push) staging <= in_last ? '0 : merged;
            if (commit) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (commit && !pop) count <= count + 1'b1;
            else if (pop && !commit) count <= count - 1'b1;
        end
    end

    // storage is never cleared; stale entries stay hidden behind count and the output gate
    always_ff @(posedge clk) begin
        if (!rst && commit) mem[wr_ptr] <= merged;
    end
endmodule

// File: tb/tb_regress_lane_fifo.sv
// tb_regress_lane_fifo: table-driven directed check of regress_lane_fifo
module tb_regress_lane_fifo;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_last, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [3:0]  in_mask;
    logic [2:0]  count;
    int          applied = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    regress_lane_fifo #(.LANE_W(8), .LANES(4), .DEPTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
    );

    typedef struct {
        logic        r, iv;
        logic [31:0] d;
        logic [3:0]  m;
        logic        l, ordy, e_ir, e_ov;
        logic [31:0] e_od;
        logic [2:0]  e_c;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] rev(input logic [31:0] x);
        logic [31:0] y;
`ifdef REGRESS_LANE_REVERSE_EN
        for (int l = 0; l < 4; l++) y[(3-l)*8 +: 8] = x[l*8 +: 8];
`else
        y = x;
`endif
        return y;
    endfunction

    task automatic add(input logic r, iv, input logic [31:0] d, input logic [3:0] m,
                       input logic l, ordy, e_ir, e_ov, input logic [31:0] e_od, input logic [2:0] e_c);
        vq.push_back('{r, iv, d, m, l, ordy, e_ir, e_ov, e_od, e_c});
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, iv, input logic [31:0] d, input logic [3:0] m, input logic l, ordy);
        rst = r; in_valid = iv; in_data = d; in_mask = m; in_last = l; out_ready = ordy;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        //   rst iv data          mask     last ordy  ir ov out_data      cnt
        add(1, 0, 32'h0,        4'h0,    0, 0,    1, 0, 32'h0,        3'd0);
        add(0, 1, 32'hDDCCBBAA, 4'hF,    1, 0,    1, 1, 32'hDDCCBBAA, 3'd1);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 0, 32'h0,        3'd0);
        add(0, 1, 32'h11223344, 4'b0011, 0, 0,    1, 0, 32'h0,        3'd0);
        add(0, 1, 32'h55667788, 4'b0100, 1, 0,    1, 1, 32'h00663344, 3'd1);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 0, 32'h0,        3'd0);
        add(0, 1, 32'd1,        4'hF,    1, 0,    1, 1, 32'd1,        3'd1);
        add(0, 1, 32'd2,        4'hF,    1, 0,    1, 1, 32'd1,        3'd2);
        add(0, 1, 32'd3,        4'hF,    1, 0,    1, 1, 32'd1,        3'd3);
        add(0, 1, 32'd4,        4'hF,    1, 0,    1, 1, 32'd1,        3'd4);
        add(0, 1, 32'd5,        4'hF,    1, 0,    0, 1, 32'd1,        3'd5);
        add(0, 1, 32'd6,        4'hF,    1, 1,    1, 1, 32'd2,        3'd4);
        add(0, 1, 32'd6,        4'hF,    1, 0,    0, 1, 32'd2,        3'd5);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 1, 32'd3,        3'd4);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 1, 32'd4,        3'd3);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 1, 32'd5,        3'd2);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 1, 32'd6,        3'd1);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 0, 32'h0,        3'd0);
        add(0, 1, 32'd7,        4'hF,    1, 0,    1, 1, 32'd7,        3'd1);
        add(0, 1, 32'd8,        4'hF,    1, 0,    1, 1, 32'd7,        3'd2);
        add(0, 1, 32'd9,        4'hF,    1, 1,    1, 1, 32'd8,        3'd2);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 1, 32'd9,        3'd1);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 0, 32'h0,        3'd0);
        add(0, 1, 32'hFFFFFFFF, 4'hF,    0, 0,    1, 0, 32'h0,        3'd0);
        add(1, 0, 32'h0,        4'h0,    0, 0,    1, 0, 32'h0,        3'd0);
        add(0, 1, 32'h000000EE, 4'b0001, 1, 0,    1, 1, 32'h000000EE, 3'd1);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 0, 32'h0,        3'd0);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 0, 32'h0,        3'd0);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 0, 32'h0,        3'd0);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 0, 32'h0,        3'd0);
        add(0, 1, 32'hFFFFFFFF, 4'h0,    1, 0,    1, 1, 32'h0,        3'd1);
        add(0, 0, 32'h0,        4'h0,    0, 1,    1, 0, 32'h0,        3'd0);
        add(0, 1, 32'h000000AA, 4'hF,    1, 0,    1, 1, 32'h000000AA, 3'd1);
        add(1, 0, 32'h0,        4'h0,    0, 0,    1, 0, 32'h0,        3'd0);
        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].iv, vq[i].d, vq[i].m, vq[i].l, vq[i].ordy);
            step();
            chk("in_ready", i, 32'(in_ready), 32'(vq[i].e_ir));
            chk("out_valid", i, 32'(out_valid), 32'(vq[i].e_ov));
            chk("out_data", i, out_data, rev(vq[i].e_od));
            chk("count", i, 32'(count), 32'(vq[i].e_c));
        end
        drive(1, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 32'h01010100 + 32'(k), 4'hF, 1, 0);
            step();
            chk("fill_count", k, 32'(count), 32'(k + 1));
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'h99999999, 4'hF, 1, 0);
            step();
            chk("full_hold_count", k, 32'(count), 32'd5);
            chk("full_hold_ready", k, 32'(in_ready), 32'd0);
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            chk("drain_valid", k, 32'(out_valid), 32'd1);
            chk("drain_data", k, out_data, rev(32'h01010100 + 32'(k)));
            step();
        end
        chk("drain_empty", 0, 32'(count), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
